clkdiv_ratio_ctrl: RTL and testbench
====================================

Name: clkdiv_ratio_ctrl

Overview:
Run-time controller for the divided-clock generator.
- Produces a divided clock-enable pulse and a divided level output from `clk`.
- Accepts divide-ratio change requests over a req/ack handshake and applies each accepted ratio only at a period boundary, so no runt pulses are produced.
- Stops and starts glitch-free on `enable`.
- Sits between the system config logic and the divided-clock consumers.

Parameters:
- CNT_W, 8, width of the divide ratio and the internal period counter.
- DEFAULT_DIV, 2, ratio loaded at reset; legal range 2..2^CNT_W-1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run the divider, 0 = stop at the next period boundary.
- div_req  in  1  ratio change request, sampled each cycle.
- div_val  in  CNT_W  requested ratio, valid when div_req=1.
- div_ack  out  1  one-cycle pulse when a request is applied or rejected.
- div_err  out  1  one-cycle pulse, coincident with div_ack, when the request was rejected.
- busy  out  1  high while an accepted request is pending.
- tick  out  1  one-cycle pulse in the first cycle of each divided period.
- div_out  out  1  registered divided level.
- cur_div  out  CNT_W  ratio currently in force.

Behaviour:
- Reset values (rst=0): state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pend=0, div_out=0, tick=0, div_ack=0, div_err=0, busy=0. Reset mid-operation discards any pending request and drops the ack.
- State machine:
  - IDLE → RUN when enable=1.
  - RUN → STOP when enable=0.
  - STOP → RUN when enable=1.
  - STOP → IDLE at the boundary cycle (cnt==cur_div-1).
- Counter:
  - In RUN or STOP, cnt increments each cycle and wraps to 0 after cur_div-1.
  - In IDLE, cnt holds at 0.
- tick: 1 in every cycle where state is RUN/STOP and cnt==0. This includes the first cycle after IDLE→RUN.
- div_out: 1 when state≠IDLE and cnt < (cur_div>>1), else 0.
  - Even N gives 50% duty.
  - Odd N gives high for floor(N/2) of N cycles.
  - div_out is 0 in IDLE.
- Start latency: enable rises at cycle k (in IDLE) → cycle k+1 shows RUN, cnt=0, tick=1, div_out=1.
- Stop: div_out and tick continue until the current period completes. IDLE is entered after cnt==cur_div-1, so the last period is always complete.
- Request handling (div_req=1 while busy=0):
  - div_val<2: reject. Next cycle div_ack=1, div_err=1; cur_div is unchanged.
  - div_val≥2: latch into pend_val, set pend=1 (busy=1 from the next cycle).
- Applying a pending ratio:
  - In IDLE: the next cycle loads cur_div=pend_val and pulses div_ack.
  - In RUN/STOP: at the boundary cycle, cur_div←pend_val and cnt←0, so the first period at the new ratio starts with tick. div_ack pulses in that same first cycle; busy clears with it.
- Requests while busy=1 are ignored: no ack, no latch. The requester must wait for div_ack.
- Simultaneous events:
  - A pending apply at the STOP boundary loads the new ratio, then enters IDLE.
  - A div_req in the same cycle as div_ack is treated as a new request (busy already cleared).
- Widths: the ratio is unsigned; cnt compare is exact; no arithmetic overflow, since cnt<cur_div≤2^CNT_W-1.

Optional Feature:
- Macro CLKDIV_PERIOD_CNT_EN.
- Defined: adds output `period_cnt` [15:0], which increments (mod 2^16) on every tick and is 0 on reset and while IDLE.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset release, enable=1, DEFAULT_DIV=2 → tick every 2 cycles; div_out 1,0,1,0…; cur_div=2.
2. While running at 2, div_req with div_val=8 at mid-period → busy=1 until the boundary; then cur_div=8, div_ack pulse, div_out high 4 / low 4, tick every 8 cycles.
3. div_req with div_val=1, then div_val=0 → div_ack+div_err pulse one cycle after each; cur_div unchanged; div_out period unchanged.
4. Running at 5, drop enable at cnt=1 → cnt continues 2,3,4; div_out high for cnt 0–1 only; then IDLE with div_out=0, tick=0. Re-enable → tick on the next cycle.
5. Second div_req while busy=1 → ignored, no extra ack; only the first value is applied.
6. Pull rst low mid-period with a request pending → all outputs 0 immediately, cur_div=DEFAULT_DIV; no div_ack after release.

Source files
------------

// File: rtl/clkdiv_ratio_ctrl.sv
// Divided clock-enable/level generator with run-time ratio change; optional CLKDIV_PERIOD_CNT_EN adds period_cnt.
// Latency: tick/div_out one cycle after enable; a new ratio lands at the next period boundary (next cycle when IDLE).
// Backpressure: one outstanding ratio request; requests while busy are dropped, requester waits for div_ack.
module clkdiv_ratio_ctrl #(
    parameter int          CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic             tick,
    output logic             div_out,
`ifdef CLKDIV_PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic [CNT_W-1:0] cur_div
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             tick_q, tick_d;
    logic             div_out_q, div_out_d;
    logic             boundary;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0]      period_cnt_q, period_cnt_d;
`endif

    assign boundary = (cnt_q == (cur_div_q - ONE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = boundary ? '0 : cnt_q + ONE;
                if (!enable) state_d = ST_STOP;
            end
            ST_STOP: begin
                cnt_d = boundary ? '0 : cnt_q + ONE;
                if (enable)        state_d = ST_RUN;
                else if (boundary) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Ratio swaps only where cnt restarts, so the old period is never cut short.
        if (pend_q && (state_q == ST_IDLE || boundary)) begin
            cur_div_d = pend_val_q;
            cnt_d     = '0;
            pend_d    = 1'b0;
            ack_d     = 1'b1;
        end

        if (div_req && !pend_q) begin
            if (div_val < MIN_DIV) begin
                ack_d = 1'b1;
                err_d = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pend_val_d = div_val;
            end
        end

        // Outputs are computed from next state so the flops show the current period position.
        tick_d    = (state_d != ST_IDLE) && (cnt_d == '0);
        div_out_d = (state_d != ST_IDLE) && (cnt_d < (cur_div_d >> 1));
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    always_comb begin
        period_cnt_d = period_cnt_q;
        if (state_d == ST_IDLE) period_cnt_d = '0;
        else if (tick_d)        period_cnt_d = period_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) period_cnt_q <= '0;
        else      period_cnt_q <= period_cnt_d;
    end

    assign period_cnt = period_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_div_q  <= CNT_W'(DEFAULT_DIV);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tick_q     <= 1'b0;
            div_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
            div_out_q  <= div_out_d;
        end
    end

    assign div_ack = ack_q;
    assign div_err = err_q;
    assign busy    = pend_q;
    assign tick    = tick_q;
    assign div_out = div_out_q;
    assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Directed bench for clkdiv_ratio_ctrl: start/stop, ratio change, reject, busy drop, async reset.
module tb_clkdiv_ratio_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       div_req;
    logic [7:0] div_val;
    logic       div_ack;
    logic       div_err;
    logic       busy;
    logic       tick;
    logic       div_out;
    logic [7:0] cur_div;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    clkdiv_ratio_ctrl #(.CNT_W(8), .DEFAULT_DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .div_req    (div_req),
        .div_val    (div_val),
        .div_ack    (div_ack),
        .div_err    (div_err),
        .busy       (busy),
        .tick       (tick),
        .div_out    (div_out),
`ifdef CLKDIV_PERIOD_CNT_EN
        .period_cnt (period_cnt),
`endif
        .cur_div    (cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ckto(input string tag, input logic exp_tick, input logic exp_out);
        chk({tag, "_tick"}, 32'(tick), 32'(exp_tick));
        chk({tag, "_div_out"}, 32'(div_out), 32'(exp_out));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        enable  = 1'b0;
        div_req = 1'b0;
        div_val = 8'd0;
        step();
        step();
        ckto("rst", 1'b0, 1'b0);
        chk("rst_cur_div", 32'(cur_div), 32'd2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(div_ack), 32'd0);
        chk("rst_err", 32'(div_err), 32'd0);

        // Run at default ratio 2: tick/div_out alternate from the first cycle.
        rst    = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            ckto("t1_run", (i % 2) == 0, (i % 2) == 0);
        end
        chk("t1_cur_div", 32'(cur_div), 32'd2);

        // Ratio 8 requested at cnt=0, applied after the cnt=1 boundary.
        step();
        div_req = 1'b1;
        div_val = 8'd8;
        step();
        div_req = 1'b0;
        chk("t2_busy_set", 32'(busy), 32'd1);
        chk("t2_cur_old", 32'(cur_div), 32'd2);
        chk("t2_ack_early", 32'(div_ack), 32'd0);
        step();
        chk("t2_ack", 32'(div_ack), 32'd1);
        chk("t2_busy_clr", 32'(busy), 32'd0);
        chk("t2_cur_new", 32'(cur_div), 32'd8);
        ckto("t2_first", 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step();
            ckto("t2_period", (i % 8) == 0, (i % 8) < 4);
            if (i == 1) chk("t2_ack_once", 32'(div_ack), 32'd0);
        end

        // Illegal ratios 1 and 0 are rejected one cycle later.
        div_req = 1'b1;
        div_val = 8'd1;
        step();
        chk("t3_ack1", 32'(div_ack), 32'd1);
        chk("t3_err1", 32'(div_err), 32'd1);
        div_val = 8'd0;
        step();
        chk("t3_ack0", 32'(div_ack), 32'd1);
        chk("t3_err0", 32'(div_err), 32'd1);
        chk("t3_cur_kept", 32'(cur_div), 32'd8);
        div_req = 1'b0;
        step();
        chk("t3_ack_clr", 32'(div_ack), 32'd0);
        chk("t3_err_clr", 32'(div_err), 32'd0);
        ckto("t3_cnt3", 1'b0, 1'b1);
        step();
        ckto("t3_cnt4", 1'b0, 1'b0);

        // Ratio 5 accepted at cnt=4; a second request (3) while busy is dropped.
        div_req = 1'b1;
        div_val = 8'd5;
        step();
        chk("t5_busy_a", 32'(busy), 32'd1);
        div_val = 8'd3;
        step();
        chk("t5_busy_b", 32'(busy), 32'd1);
        chk("t5_no_ack", 32'(div_ack), 32'd0);
        div_req = 1'b0;
        step();
        chk("t5_ack_cnt7", 32'(div_ack), 32'd0);
        chk("t5_cur_before", 32'(cur_div), 32'd8);
        step();
        chk("t5_cur_new", 32'(cur_div), 32'd5);
        chk("t5_ack", 32'(div_ack), 32'd1);
        chk("t5_busy_clr", 32'(busy), 32'd0);
        ckto("t5_first", 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step();
            ckto("t5_period", (i % 5) == 0, (i % 5) < 2);
            chk("t5_no_extra_ack", 32'(div_ack), 32'd0);
        end
        chk("t5_cur_final", 32'(cur_div), 32'd5);

        // Drop enable at cnt=1: period finishes 2,3,4 then IDLE.
        step();
        ckto("t4_cnt1", 1'b0, 1'b1);
        enable = 1'b0;
        step();
        ckto("t4_stop_cnt2", 1'b0, 1'b0);
        step();
        ckto("t4_stop_cnt3", 1'b0, 1'b0);
        step();
        ckto("t4_stop_cnt4", 1'b0, 1'b0);
        step();
        ckto("t4_idle_a", 1'b0, 1'b0);
        step();
        ckto("t4_idle_b", 1'b0, 1'b0);
        enable = 1'b1;
        step();
        ckto("t4_restart", 1'b1, 1'b1);
        step();
        ckto("t4_restart_cnt1", 1'b0, 1'b1);
        step();
        ckto("t4_restart_cnt2", 1'b0, 1'b0);

        // Async reset mid-period with a request pending.
        div_req = 1'b1;
        div_val = 8'd9;
        step();
        chk("t6_busy_pre", 32'(busy), 32'd1);
        div_req = 1'b0;
        enable  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        ckto("t6_rst_now", 1'b0, 1'b0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ack", 32'(div_ack), 32'd0);
        chk("t6_rst_cur", 32'(cur_div), 32'd2);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_post_ack", 32'(div_ack), 32'd0);
            chk("t6_post_busy", 32'(busy), 32'd0);
            chk("t6_post_cur", 32'(cur_div), 32'd2);
            ckto("t6_post_idle", 1'b0, 1'b0);
        end
        enable = 1'b1;
        step();
        ckto("t6_restart", 1'b1, 1'b1);
        step();
        ckto("t6_restart_cnt1", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
